// File: rtl/vga_timing_gen_param.sv
// Parametrised VGA timing generator with CE gating, active coordinates,
// double-buffered image window, line/frame strobes and a frame counter.
module vga_timing_gen_param #(
  parameter int H_SYNC   = 95,
  parameter int H_BP     = 48,
  parameter int H_ACTIVE = 635,
  parameter int H_FP     = 15,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int CNT_W    = 10,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int FRAME_W  = 8
) (
  input  logic               i_clk_27,
  input  logic               i_arst,
  input  logic               i_on,
  input  logic               i_ce,
  input  logic               i_win_load,
  input  logic [CNT_W-1:0]   i_win_x0,
  input  logic [CNT_W-1:0]   i_win_x1,
  input  logic [CNT_W-1:0]   i_win_y0,
  input  logic [CNT_W-1:0]   i_win_y1,
  output logic [CNT_W-1:0]   o_hcnt,
  output logic [CNT_W-1:0]   o_vcnt,
  output logic [CNT_W-1:0]   o_x,
  output logic [CNT_W-1:0]   o_y,
  output logic               o_hsync,
  output logic               o_vsync,
  output logic               o_blank_n,
  output logic               o_active_area,
  output logic               o_image_active,
  output logic               o_line_start,
  output logic               o_frame_start,
  output logic [FRAME_W-1:0] o_frame_cnt,
  output logic               o_sync
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_SYNC);
  localparam logic [CNT_W-1:0] HA0 = CNT_W'(H_SYNC + H_BP);
  localparam logic [CNT_W-1:0] HA1 = CNT_W'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [CNT_W-1:0] VA0 = CNT_W'(V_SYNC + V_BP);
  localparam logic [CNT_W-1:0] VA1 = CNT_W'(V_SYNC + V_BP + V_ACTIVE);

  localparam logic HS_ON = (HS_POL != 0);
  localparam logic VS_ON = (VS_POL != 0);

  localparam logic [CNT_W-1:0] WX0_RST = '0;
  localparam logic [CNT_W-1:0] WX1_RST = CNT_W'(128);
  localparam logic [CNT_W-1:0] WY0_RST = '0;
  localparam logic [CNT_W-1:0] WY1_RST = CNT_W'(160);

  logic               on_q, on_d;
  logic [CNT_W-1:0]   hcnt_q, hcnt_d;
  logic [CNT_W-1:0]   vcnt_q, vcnt_d;
  logic [CNT_W-1:0]   x_q, x_d;
  logic [CNT_W-1:0]   y_q, y_d;
  logic               hsync_q, hsync_d;
  logic               vsync_q, vsync_d;
  logic               active_q, active_d;
  logic               img_q, img_d;
  logic               line_q, line_d;
  logic               frame_q, frame_d;
  logic [FRAME_W-1:0] fcnt_q, fcnt_d;

  logic [CNT_W-1:0] sx0_q, sx0_d, sx1_q, sx1_d;
  logic [CNT_W-1:0] sy0_q, sy0_d, sy1_q, sy1_d;
  logic [CNT_W-1:0] wx0_q, wx0_d, wx1_q, wx1_d;
  logic [CNT_W-1:0] wy0_q, wy0_d, wy1_q, wy1_d;

  logic             start, adv, wrap, act;
  logic [CNT_W-1:0] xc, yc;

  always_comb begin
    on_d   = i_on;
    start  = i_on & ~on_q;
    adv    = i_on & on_q & i_ce;
    wrap   = 1'b0;
    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;

    if (!i_on || start) begin
      hcnt_d = '0;
      vcnt_d = '0;
    end else if (adv) begin
      if (hcnt_q == H_LAST) begin
        hcnt_d = '0;
        if (vcnt_q == V_LAST) begin
          vcnt_d = '0;
          wrap   = 1'b1;
        end else begin
          vcnt_d = vcnt_q + 1'b1;
        end
      end else begin
        hcnt_d = hcnt_q + 1'b1;
      end
    end

    sx0_d = sx0_q;
    sx1_d = sx1_q;
    sy0_d = sy0_q;
    sy1_d = sy1_q;
    if (i_win_load) begin
      sx0_d = i_win_x0;
      sx1_d = i_win_x1;
      sy0_d = i_win_y0;
      sy1_d = i_win_y1;
    end

    // a load coinciding with the wrap only reaches the shadow
    wx0_d = wrap ? sx0_q : wx0_q;
    wx1_d = wrap ? sx1_q : wx1_q;
    wy0_d = wrap ? sy0_q : wy0_q;
    wy1_d = wrap ? sy1_q : wy1_q;

    // decode the next counter value so outputs align with o_hcnt/o_vcnt
    act = i_on
        && (hcnt_d >= HA0) && (hcnt_d < HA1)
        && (vcnt_d >= VA0) && (vcnt_d < VA1);
    xc  = hcnt_d - HA0;
    yc  = vcnt_d - VA0;

    active_d = act;
    x_d      = act ? xc : '0;
    y_d      = act ? yc : '0;
    img_d    = act
             && (xc >= wx0_d) && (xc < wx1_d)
             && (yc >= wy0_d) && (yc < wy1_d);

    hsync_d = (i_on && (hcnt_d < HS_END)) ? HS_ON : ~HS_ON;
    vsync_d = (i_on && (vcnt_d < VS_END)) ? VS_ON : ~VS_ON;

    line_d  = start | (adv & (hcnt_d == '0));
    frame_d = start | wrap;

    fcnt_d = fcnt_q;
    if (wrap) fcnt_d = fcnt_q + 1'b1;
  end

  always_ff @(posedge i_clk_27 or posedge i_arst) begin
    if (i_arst) begin
      on_q     <= 1'b0;
      hcnt_q   <= '0;
      vcnt_q   <= '0;
      x_q      <= '0;
      y_q      <= '0;
      hsync_q  <= ~HS_ON;
      vsync_q  <= ~VS_ON;
      active_q <= 1'b0;
      img_q    <= 1'b0;
      line_q   <= 1'b0;
      frame_q  <= 1'b0;
      fcnt_q   <= '0;
      sx0_q    <= WX0_RST;
      sx1_q    <= WX1_RST;
      sy0_q    <= WY0_RST;
      sy1_q    <= WY1_RST;
      wx0_q    <= WX0_RST;
      wx1_q    <= WX1_RST;
      wy0_q    <= WY0_RST;
      wy1_q    <= WY1_RST;
    end else begin
      on_q     <= on_d;
      hcnt_q   <= hcnt_d;
      vcnt_q   <= vcnt_d;
      x_q      <= x_d;
      y_q      <= y_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      active_q <= active_d;
      img_q    <= img_d;
      line_q   <= line_d;
      frame_q  <= frame_d;
      fcnt_q   <= fcnt_d;
      sx0_q    <= sx0_d;
      sx1_q    <= sx1_d;
      sy0_q    <= sy0_d;
      sy1_q    <= sy1_d;
      wx0_q    <= wx0_d;
      wx1_q    <= wx1_d;
      wy0_q    <= wy0_d;
      wy1_q    <= wy1_d;
    end
  end

  assign o_hcnt         = hcnt_q;
  assign o_vcnt         = vcnt_q;
  assign o_x            = x_q;
  assign o_y            = y_q;
  assign o_hsync        = hsync_q;
  assign o_vsync        = vsync_q;
  assign o_blank_n      = active_q;
  assign o_active_area  = active_q;
  assign o_image_active = img_q;
  assign o_line_start   = line_q;
  assign o_frame_start  = frame_q;
  assign o_frame_cnt    = fcnt_q;
  assign o_sync         = 1'b0;

endmodule

// File: tb/tb_vga_timing_gen_param.sv
// Directed bench: default-timing instance for line-level decode, small
// instances for frame-level behaviour and inverted sync polarity.
module tb_vga_timing_gen_param;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic on  = 1'b0;
  logic ce  = 1'b0;
  logic ld  = 1'b0;
  logic [9:0] wx0 = '0, wx1 = '0, wy0 = '0, wy1 = '0;

  always #5 clk = ~clk;

  // small timing: H 4+3+10+2=19 (HA0 7), V 2+3+8+2=15 (VA0 5)
  logic [9:0] s_hcnt, s_vcnt, s_x, s_y;
  logic       s_hs, s_vs, s_bl, s_act, s_img, s_line, s_frame, s_sync;
  logic [7:0] s_fcnt;

  logic [9:0] d_hcnt, d_vcnt, d_x, d_y;
  logic       d_hs, d_vs, d_bl, d_act, d_img, d_line, d_frame, d_sync;
  logic [7:0] d_fcnt;

  logic [9:0] p_hcnt, p_vcnt, p_x, p_y;
  logic       p_hs, p_vs, p_bl, p_act, p_img, p_line, p_frame, p_sync;
  logic [7:0] p_fcnt;

  vga_timing_gen_param #(
    .H_SYNC(4), .H_BP(3), .H_ACTIVE(10), .H_FP(2),
    .V_SYNC(2), .V_BP(3), .V_ACTIVE(8), .V_FP(2)
  ) u_s (
    .i_clk_27(clk), .i_arst(rst), .i_on(on), .i_ce(ce),
    .i_win_load(ld), .i_win_x0(wx0), .i_win_x1(wx1),
    .i_win_y0(wy0), .i_win_y1(wy1),
    .o_hcnt(s_hcnt), .o_vcnt(s_vcnt), .o_x(s_x), .o_y(s_y),
    .o_hsync(s_hs), .o_vsync(s_vs), .o_blank_n(s_bl),
    .o_active_area(s_act), .o_image_active(s_img),
    .o_line_start(s_line), .o_frame_start(s_frame),
    .o_frame_cnt(s_fcnt), .o_sync(s_sync)
  );

  vga_timing_gen_param u_d (
    .i_clk_27(clk), .i_arst(rst), .i_on(on), .i_ce(ce),
    .i_win_load(ld), .i_win_x0(wx0), .i_win_x1(wx1),
    .i_win_y0(wy0), .i_win_y1(wy1),
    .o_hcnt(d_hcnt), .o_vcnt(d_vcnt), .o_x(d_x), .o_y(d_y),
    .o_hsync(d_hs), .o_vsync(d_vs), .o_blank_n(d_bl),
    .o_active_area(d_act), .o_image_active(d_img),
    .o_line_start(d_line), .o_frame_start(d_frame),
    .o_frame_cnt(d_fcnt), .o_sync(d_sync)
  );

  vga_timing_gen_param #(
    .H_SYNC(4), .H_BP(3), .H_ACTIVE(10), .H_FP(2),
    .V_SYNC(2), .V_BP(3), .V_ACTIVE(8), .V_FP(2),
    .HS_POL(1), .VS_POL(1)
  ) u_p (
    .i_clk_27(clk), .i_arst(rst), .i_on(on), .i_ce(ce),
    .i_win_load(ld), .i_win_x0(wx0), .i_win_x1(wx1),
    .i_win_y0(wy0), .i_win_y1(wy1),
    .o_hcnt(p_hcnt), .o_vcnt(p_vcnt), .o_x(p_x), .o_y(p_y),
    .o_hsync(p_hs), .o_vsync(p_vs), .o_blank_n(p_bl),
    .o_active_area(p_act), .o_image_active(p_img),
    .o_line_start(p_line), .o_frame_start(p_frame),
    .o_frame_cnt(p_fcnt), .o_sync(p_sync)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_s(input int h, input int v);
    bit hit = 0;
    for (int i = 0; i < 2000; i++) begin
      if (s_hcnt == h[9:0] && (v < 0 || s_vcnt == v[9:0])) begin
        hit = 1;
        break;
      end
      tick();
    end
    if (!hit) chk("wait_s_timeout", 0, 1);
  endtask

  task automatic wait_d(input int h, input int v);
    bit hit = 0;
    for (int i = 0; i < 50000; i++) begin
      if (d_hcnt == h[9:0] && d_vcnt == v[9:0]) begin
        hit = 1;
        break;
      end
      tick();
    end
    if (!hit) chk("wait_d_timeout", 0, 1);
  endtask

  // count image_active pixels until the next frame start
  task automatic count_frame(input int x0, input int x1,
                             input int y0, input int y1,
                             output int n, output int bad);
    bit hit = 0;
    n   = 0;
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (s_img) begin
        n++;
        if (s_x < x0 || s_x >= x1 || s_y < y0 || s_y >= y1) bad++;
      end
      if (s_frame) begin
        hit = 1;
        break;
      end
    end
    if (!hit) chk("frame_timeout", 0, 1);
  endtask

  task automatic load(input int x0, input int x1,
                      input int y0, input int y1);
    wx0 = x0[9:0];
    wx1 = x1[9:0];
    wy0 = y0[9:0];
    wy1 = y1[9:0];
    ld  = 1'b1;
  endtask

  int n, bad;

  initial begin
    #1 rst = 1'b1;
    tick();
    tick();
    chk("rst_hcnt", s_hcnt, 0);
    chk("rst_vcnt", s_vcnt, 0);
    chk("rst_hs", s_hs, 1);
    chk("rst_vs", s_vs, 1);
    chk("rst_blank", s_bl, 0);
    chk("rst_img", s_img, 0);
    chk("rst_line", s_line, 0);
    chk("rst_fcnt", s_fcnt, 0);
    chk("rst_p_hs", p_hs, 0);
    chk("rst_p_vs", p_vs, 0);
    chk("rst_sync", s_sync, 0);

    rst = 1'b0;
    on  = 1'b1;
    ce  = 1'b1;
    tick();
    chk("start_line", s_line, 1);
    chk("start_frame", s_frame, 1);
    chk("start_hcnt", s_hcnt, 0);
    chk("start_d_hcnt", d_hcnt, 0);
    chk("start_hs", s_hs, 0);
    chk("start_p_hs", p_hs, 1);
    chk("start_p_vs", p_vs, 1);
    chk("start_fcnt", s_fcnt, 0);
    tick();
    chk("t1_line", s_line, 0);
    chk("t1_hcnt", s_hcnt, 1);

    n = 1;
    do begin
      tick();
      n++;
    end while (!s_line && n < 100);
    chk("s_line_period", n, 19);
    chk("s_vcnt_1", s_vcnt, 1);
    chk("s_vs_v1", s_vs, 0);
    wait_s(3, 2);
    chk("s_hs_h3", s_hs, 0);
    chk("s_vs_v2", s_vs, 1);
    tick();
    chk("s_hs_h4", s_hs, 1);
    chk("p_hs_h4", p_hs, 0);
    chk("p_vs_v2", p_vs, 0);

    wait_s(6, 5);
    chk("s_bl_h6", s_bl, 0);
    tick();
    chk("s_bl_h7", s_bl, 1);
    chk("s_x_h7", s_x, 0);
    chk("s_y_v5", s_y, 0);
    chk("s_act_h7", s_act, 1);
    chk("s_img_h7", s_img, 1);
    wait_s(16, 5);
    chk("s_x_h16", s_x, 9);
    tick();
    chk("s_bl_h17", s_bl, 0);
    chk("s_x_h17", s_x, 0);
    wait_s(7, 12);
    chk("s_y_v12", s_y, 7);
    wait_s(7, 13);
    chk("s_bl_v13", s_bl, 0);
    chk("s_y_v13", s_y, 0);

    wait_s(0, 0);
    chk("wrap1_frame", s_frame, 1);
    chk("wrap1_fcnt", s_fcnt, 1);
    n = 0;
    do begin
      tick();
      n++;
    end while (!s_frame && n < 1000);
    chk("s_frame_period", n, 285);
    chk("wrap2_fcnt", s_fcnt, 2);

    wait_s(0, 3);
    load(2, 5, 1, 3);
    tick();
    ld = 1'b0;
    count_frame(0, 128, 0, 160, n, bad);
    chk("win_old_n", n, 80);
    count_frame(2, 5, 1, 3, n, bad);
    chk("win_new_n", n, 6);
    chk("win_new_bad", bad, 0);

    load(3, 3, 0, 8);
    tick();
    ld = 1'b0;
    count_frame(2, 5, 1, 3, n, bad);
    chk("win_pend_n", n, 6);
    count_frame(0, 128, 0, 160, n, bad);
    chk("win_empty_n", n, 0);

    wait_s(18, 14);
    load(0, 128, 0, 160);
    tick();
    ld = 1'b0;
    chk("wrapload_frame", s_frame, 1);
    count_frame(0, 128, 0, 160, n, bad);
    chk("wrapload_n0", n, 0);
    count_frame(0, 128, 0, 160, n, bad);
    chk("wrapload_n1", n, 80);

    wait_d(142, 35);
    chk("d_bl_142", d_bl, 0);
    tick();
    chk("d_bl_143", d_bl, 1);
    chk("d_x_143", d_x, 0);
    chk("d_y_35", d_y, 0);
    wait_d(777, 35);
    chk("d_x_777", d_x, 634);
    tick();
    chk("d_bl_778", d_bl, 0);
    chk("d_x_778", d_x, 0);
    wait_d(0, 36);
    n = 0;
    do begin
      tick();
      n++;
    end while (!d_line && n < 2000);
    chk("d_line_period", n, 793);
    wait_d(94, 37);
    chk("d_hs_94", d_hs, 0);
    tick();
    chk("d_hs_95", d_hs, 1);

    wait_s(18, -1);
    ce = 1'b1;
    tick();
    chk("ce_h0", s_hcnt, 0);
    chk("ce_line", s_line, 1);
    ce = 1'b0;
    tick();
    chk("ce_hold0", s_hcnt, 0);
    chk("ce_line_w", s_line, 0);
    ce = 1'b1;
    tick();
    chk("ce_h1", s_hcnt, 1);
    ce = 1'b0;
    tick();
    chk("ce_hold1", s_hcnt, 1);
    n = 3;
    while (n < 100) begin
      n++;
      ce = (n % 2 == 0);
      tick();
      if (s_line) break;
    end
    chk("ce_line_period", n, 38);
    ce = 1'b1;
    tick();
    chk("ce_line_end", s_line, 0);
    chk("ce_h1b", s_hcnt, 1);

    wait_s(10, 7);
    #3 rst = 1'b1;
    #1;
    chk("arst_hcnt", s_hcnt, 0);
    chk("arst_vcnt", s_vcnt, 0);
    chk("arst_x", s_x, 0);
    chk("arst_bl", s_bl, 0);
    chk("arst_img", s_img, 0);
    chk("arst_hs", s_hs, 1);
    chk("arst_p_hs", p_hs, 0);
    chk("arst_fcnt", s_fcnt, 0);
    chk("arst_line", s_line, 0);
    tick();
    rst = 1'b0;
    tick();
    chk("rest_line", s_line, 1);
    chk("rest_frame", s_frame, 1);
    chk("rest_fcnt", s_fcnt, 0);
    count_frame(0, 128, 0, 160, n, bad);
    chk("rest_n", n, 80);
    chk("rest_fcnt1", s_fcnt, 1);

    wait_s(10, 7);
    on = 1'b0;
    load(0, 1, 0, 1);
    tick();
    ld = 1'b0;
    chk("off_hcnt", s_hcnt, 0);
    chk("off_vcnt", s_vcnt, 0);
    chk("off_hs", s_hs, 1);
    chk("off_vs", s_vs, 1);
    chk("off_p_hs", p_hs, 0);
    chk("off_bl", s_bl, 0);
    chk("off_act", s_act, 0);
    chk("off_line", s_line, 0);
    tick();
    tick();
    tick();
    chk("idle_p_vs", p_vs, 0);
    chk("idle_frame", s_frame, 0);
    on = 1'b1;
    tick();
    chk("reon_line", s_line, 1);
    chk("reon_frame", s_frame, 1);
    chk("reon_hcnt", s_hcnt, 0);
    chk("reon_vcnt", s_vcnt, 0);
    chk("reon_fcnt", s_fcnt, 1);
    tick();
    chk("reon_line_w", s_line, 0);
    count_frame(0, 128, 0, 160, n, bad);
    chk("reon_n_old", n, 80);
    count_frame(0, 1, 0, 1, n, bad);
    chk("reon_n_new", n, 1);
    chk("reon_bad", bad, 0);
    chk("reon_fcnt3", s_fcnt, 3);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen_param.md
Name: vga_timing_gen_param

Overview:
Parametrised VGA timing generator, successor to the fixed 640x480 timing block. It feeds the BAM pixel renderer and the DAC/RAMDAC output stage. Over the fixed block it adds:
- generic H/V timing and sync polarity
- pixel-clock-enable gating
- active-area pixel coordinates
- a runtime-programmable image window, double-buffered and applied at frame boundary
- line/frame start strobes and a frame counter

All outputs are registered.

Parameters:
H_SYNC, 95, hsync width in pixel clocks
H_BP, 48, horizontal back porch
H_ACTIVE, 635, horizontal active pixels
H_FP, 15, horizontal front porch
V_SYNC, 2, vsync width in lines
V_BP, 33, vertical back porch
V_ACTIVE, 480, active lines
V_FP, 10, vertical front porch
CNT_W, 10, counter/coordinate width; must hold H_TOTAL-1 and V_TOTAL-1
HS_POL, 0, hsync asserted level (0 = active-low)
VS_POL, 0, vsync asserted level
FRAME_W, 8, frame counter width
Derived: H_TOTAL = sum of the H terms (793); V_TOTAL = sum of the V terms (525); HA0 = H_SYNC+H_BP (143); VA0 = V_SYNC+V_BP (35).

Ports:
i_clk_27  in  1  pixel-domain clock
i_arst  in  1  asynchronous reset, active-high
i_on  in  1  generator enable; low holds the generator idle
i_ce  in  1  pixel clock enable; counters advance only when i_on & i_ce
i_win_load  in  1  one-clock strobe that captures the window inputs into shadow registers
i_win_x0, i_win_x1  in  CNT_W  window x start (inclusive) and end (exclusive), in active coordinates
i_win_y0, i_win_y1  in  CNT_W  window y start (inclusive) and end (exclusive)
o_hcnt, o_vcnt  out  CNT_W  raw counters
o_x, o_y  out  CNT_W  active-area coordinates (hcnt-HA0, vcnt-VA0); 0 outside the active area
o_hsync, o_vsync  out  1  sync, polarity per HS_POL/VS_POL
o_blank_n  out  1  1 only inside the active area
o_active_area  out  1  inside the active area
o_image_active  out  1  inside the active area and the current window
o_line_start, o_frame_start  out  1  one-clock strobes
o_frame_cnt  out  FRAME_W  completed-frame count
o_sync  out  1  tied 0 (no sync-on-green)

Behaviour:
- Reset (i_arst=1, async), all registered outputs:
  - counters, o_x, o_y, strobes, o_frame_cnt = 0
  - o_hsync=~HS_POL, o_vsync=~VS_POL
  - o_blank_n, o_active_area, o_image_active = 0
  - active and shadow window = x[0,128), y[0,160)
- Advance rule, when i_on & i_ce:
  - hcnt increments; at H_TOTAL-1 it wraps to 0 and vcnt increments.
  - vcnt wraps at V_TOTAL-1 to 0.
  - With i_ce=0, all counters and decoded outputs hold; strobes are 0.
- Alignment: every decoded output is registered from the next-counter value, so in any clock it is exactly the decode of o_hcnt/o_vcnt held in that clock. Latency from counter to decode is zero.
- Sync decode: hsync asserted for hcnt < H_SYNC; vsync asserted for vcnt < V_SYNC.
- Active decode: active = (HA0 <= hcnt < HA0+H_ACTIVE) and (VA0 <= vcnt < VA0+V_ACTIVE).
- Window decode: image_active = active and x0 <= o_x < x1 and y0 <= o_y < y1. If x0 >= x1 or y0 >= y1, the window is empty and image_active stays 0.
- Window double-buffering:
  - i_win_load copies the inputs to the shadow registers; a later load overwrites an earlier one.
  - Shadow copies into the active window on the clock the counters wrap to (0,0).
  - A load in the same clock as the wrap lands in the shadow only and takes effect one frame later.
- Strobes:
  - o_line_start = 1 for one clock when the counters advance into hcnt=0.
  - o_frame_start = 1 for one clock when they advance into (0,0).
  - Both also fire once on the first clock after i_on rises.
- o_frame_cnt increments, modulo 2^FRAME_W, on each (0,0) wrap. It is cleared only by reset, not by i_on.
- i_on=0:
  - counters are forced to 0; sync outputs are deasserted, not decoded.
  - o_blank_n, o_active_area, o_image_active and the strobes = 0.
  - Shadow loads are still accepted.
- i_on falling mid-frame: the next clock is idle as above. On re-enable the generator restarts at (0,0).
- Reset asserted mid-frame: immediate return to reset values, with no partial strobe.

Test Plan:
- Reset, then i_on=1, i_ce=1, defaults for 2 frames:
  - line period 793 clocks; frame period 416325 clocks
  - o_hsync low for hcnt 0..94; o_vsync low for vcnt 0..1
  - o_frame_cnt = 2 after two wraps
- Active area decode:
  - o_x=0, o_y=0 and o_blank_n rising at hcnt=143, vcnt=35
  - o_x=634 at hcnt=777; o_blank_n=0 at hcnt=778 and at vcnt=515
- i_ce toggled 1-of-2: line period 1586 clocks, counters hold on ce=0 clocks, strobes width exactly 1 clock.
- Window update:
  - i_win_load with x[10,20), y[5,7) at vcnt=100: the current frame still uses [0,128)x[0,160).
  - The next frame gives o_image_active only at o_x 10..19, o_y 5..6 (20 pixels per frame).
  - A load with x0=x1=50 gives image_active=0 for the whole frame.
- HS_POL=1, VS_POL=1 instance: o_hsync high for hcnt 0..94, low otherwise; idle (i_on=0) level 0.
- i_on dropped at hcnt=400, vcnt=200:
  - next clock counters=0, syncs inactive, blank_n=0
  - re-raise gives o_frame_start and o_line_start high one clock at (0,0), and o_frame_cnt unchanged
  - i_arst pulse mid-frame returns all outputs to reset values asynchronously.
